// File: rtl/fta_split128to64.sv
// Sequences one 128-bit FTA request onto a 64-bit FTA slave as one or two beats
// and merges the returned acks into a single 128-bit response.
package fta_pkg;
   typedef enum logic [2:0] {BYT = 3'd0, WYDE = 3'd1, TETRA = 3'd2, OCTA = 3'd3, HEXI = 3'd4} fta_size_t;

   typedef struct packed {
      logic [1:0]   om;
      logic [4:0]   cmd;
      logic [3:0]   cid;
      logic [7:0]   tid;
      logic [1:0]   bte;
      logic [5:0]   blen;
      logic [2:0]   cti;
      logic [2:0]   seg;
      logic         cyc;
      logic         stb;
      logic         we;
      logic [15:0]  asid;
      logic [7:0]   pl;
      logic [3:0]   pri;
      logic [3:0]   cache;
      logic         csr;
      logic [31:0]  vadr;
      logic [31:0]  padr;
      fta_size_t    sz;
      logic [15:0]  sel;
      logic [127:0] data1;
   } fta_cmd_request128_t;

   typedef struct packed {
      logic [1:0]  om;
      logic [4:0]  cmd;
      logic [3:0]  cid;
      logic [7:0]  tid;
      logic [1:0]  bte;
      logic [5:0]  blen;
      logic [2:0]  cti;
      logic [2:0]  seg;
      logic        cyc;
      logic        stb;
      logic        we;
      logic [15:0] asid;
      logic [7:0]  pl;
      logic [3:0]  pri;
      logic [3:0]  cache;
      logic        csr;
      logic [31:0] vadr;
      logic [31:0] padr;
      fta_size_t   sz;
      logic [7:0]  sel;
      logic [63:0] data1;
   } fta_cmd_request64_t;

   typedef struct packed {
      logic [3:0]   cid;
      logic [7:0]   tid;
      logic [3:0]   pri;
      logic         stall;
      logic         next;
      logic         ack;
      logic         err;
      logic         rty;
      logic [31:0]  adr;
      logic [127:0] dat;
   } fta_cmd_response128_t;

   typedef struct packed {
      logic [3:0]  cid;
      logic [7:0]  tid;
      logic [3:0]  pri;
      logic        stall;
      logic        ack;
      logic        err;
      logic        rty;
      logic [31:0] adr;
      logic [63:0] dat;
   } fta_cmd_response64_t;
endpackage

module fta_split128to64
   import fta_pkg::*;
#(
   parameter int TMO = 1023
) (
   input  logic                 rst_i,
   input  logic                 clk_i,
   input  fta_cmd_request128_t  req128_i,
   output fta_cmd_response128_t resp128_o,
   output fta_cmd_request64_t   req64_o,
   input  fta_cmd_response64_t  resp64_i
);
   typedef enum logic [2:0] {IDLE, ISS_LO, ISS_HI, WAIT, RESP, ERR} state_t;

   localparam logic [9:0] TMO_LAST = 10'(TMO - 1);

   state_t              state, state_nx;
   fta_cmd_request128_t req;
   logic                split, hi_only;
   logic [1:0]          ack_cnt, ack_cnt_nx, ack_need;
   logic                err_acc, rty_acc;
   logic [9:0]          tmo_cnt;
   logic [63:0]         lo_dat, hi_dat;

   logic accept, issue, ack_in, all_acked, timeout;
   logic cls_split, cls_hi;
   logic unused_ok;

   assign cls_split = (req128_i.sz == HEXI) || ((|req128_i.sel[15:8]) && (|req128_i.sel[7:0]));
   assign cls_hi    = (|req128_i.sel[15:8]) && !cls_split;

   assign accept     = (state == IDLE) && req128_i.cyc;
   assign issue      = ((state == ISS_LO) || (state == ISS_HI)) && !resp64_i.stall;
   assign ack_need   = split ? 2'd2 : 2'd1;
   // Acks are matched to beats purely by arrival order; extras beyond the beat count are dropped.
   assign ack_in     = resp64_i.ack && (ack_cnt != ack_need) &&
                       ((state == ISS_LO) || (state == ISS_HI) || (state == WAIT));
   assign ack_cnt_nx = ack_cnt + {1'b0, ack_in};
   assign all_acked  = (ack_cnt_nx == ack_need);
   assign timeout    = (state == WAIT) && !ack_in && (tmo_cnt == TMO_LAST);

   assign unused_ok = ^{resp64_i.cid, resp64_i.tid, resp64_i.pri, resp64_i.adr, req.cyc, req.stb};

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req128_i.sz == OCTA) state_nx = ERR;
               else if (cls_hi)         state_nx = ISS_HI;
               else                     state_nx = ISS_LO;
            end
         end
         ISS_LO: begin
            if (issue) begin
               if (split)          state_nx = ISS_HI;
               else if (all_acked) state_nx = RESP;
               else                state_nx = WAIT;
            end
         end
         ISS_HI: begin
            if (issue) state_nx = all_acked ? RESP : WAIT;
         end
         WAIT: begin
            if (all_acked || timeout) state_nx = RESP;
         end
         RESP:    state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         split   <= 1'b0;
         hi_only <= 1'b0;
         ack_cnt <= 2'd0;
         err_acc <= 1'b0;
         rty_acc <= 1'b0;
         tmo_cnt <= 10'd0;
      end else begin
         state <= state_nx;
         if (accept) begin
            split   <= cls_split;
            hi_only <= cls_hi;
            ack_cnt <= 2'd0;
            err_acc <= 1'b0;
            rty_acc <= 1'b0;
            tmo_cnt <= 10'd0;
         end else begin
            ack_cnt <= ack_cnt_nx;
            err_acc <= err_acc | (ack_in & resp64_i.err) | timeout;
            rty_acc <= rty_acc | (ack_in & resp64_i.rty);
            if (issue || ack_in)    tmo_cnt <= 10'd0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + 10'd1;
         end
      end
   end

   // Request and lane data need no reset: outputs are gated by state and lanes clear on accept.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         req    <= req128_i;
         lo_dat <= 64'd0;
         hi_dat <= 64'd0;
      end else if (ack_in) begin
         if (hi_only || (ack_cnt == 2'd1)) hi_dat <= resp64_i.dat;
         else                              lo_dat <= resp64_i.dat;
      end
   end

   always_comb begin
      req64_o         = '0;
      resp128_o       = '0;
      resp128_o.stall = (state != IDLE);
      if ((state == ISS_LO) || (state == ISS_HI)) begin
         req64_o.om    = req.om;
         req64_o.cmd   = req.cmd;
         req64_o.cid   = req.cid;
         req64_o.tid   = req.tid;
         req64_o.bte   = req.bte;
         req64_o.blen  = req.blen;
         req64_o.cti   = req.cti;
         req64_o.seg   = req.seg;
         req64_o.cyc   = 1'b1;
         req64_o.stb   = 1'b1;
         req64_o.we    = req.we;
         req64_o.asid  = req.asid;
         req64_o.pl    = req.pl;
         req64_o.pri   = req.pri;
         req64_o.cache = req.cache;
         req64_o.csr   = req.csr;
         req64_o.vadr  = req.vadr;
         req64_o.sz    = split ? OCTA : req.sz;
         req64_o.padr  = {req.padr[31:4], (state == ISS_HI), 3'b000};
         req64_o.sel   = (state == ISS_HI) ? req.sel[15:8] : req.sel[7:0];
         req64_o.data1 = (state == ISS_HI) ? req.data1[127:64] : req.data1[63:0];
      end
      if ((state == RESP) || (state == ERR)) begin
         resp128_o.ack = 1'b1;
         resp128_o.cid = req.cid;
         resp128_o.tid = req.tid;
         resp128_o.pri = req.pri;
         resp128_o.adr = req.padr;
         resp128_o.err = (state == ERR) || err_acc;
         resp128_o.rty = (state == RESP) && rty_acc;
         if (state == RESP) begin
            if (split)        resp128_o.dat = {hi_dat, lo_dat};
            else if (hi_only) resp128_o.dat = {2{hi_dat}};
            else              resp128_o.dat = {2{lo_dat}};
         end
      end
   end
endmodule

// File: doc/fta_split128to64.md
Name: fta_split128to64

Overview:
Sequencer in front of a 128-to-64 FTA bus narrowing path.
- Accepts one 128-bit FTA request at a time from an upstream master.
- Issues it to a 64-bit FTA slave as one beat or two, then returns a single merged 128-bit response.
- Removes the size restriction of the combinational narrowing bridge: hexi (128-bit) accesses and byte selects spanning both 64-bit halves are split into a low beat and a high beat.
- Rejects octa with an error.

Parameters:
TMO, 1023, cycles to wait for each downstream ack before aborting with err (10-bit counter).

Ports:
rst_i  in  1  asynchronous active-high reset.
clk_i  in  1  clock.
req128_i  in  fta_cmd_request128_t  upstream request; valid when cyc=1.
resp128_o  out  fta_cmd_response128_t  upstream response; stall used as accept back-pressure.
req64_o  out  fta_cmd_request64_t  downstream request.
resp64_i  in  fta_cmd_response64_t  downstream response; the slave returns acks in issue order.

Behaviour:
- Reset: state=IDLE; all req64_o fields 0 (cyc=stb=we=0); all resp128_o fields 0 except stall=0; counters 0.
- Accept: in IDLE with req128_i.cyc=1 and resp128_o.stall=0, latch the request. stall=1 in every state except IDLE.
- Classify on accept:
  - octa -> ERR.
  - hexi, or sel[15:8]!=0 and sel[7:0]!=0 -> split (two beats).
  - sel[15:8]!=0 only -> single beat HI.
  - Otherwise -> single beat LO.
  - sel=0 with cyc=1 -> single beat LO with sel 0.
- Beat fields: all sideband copied unchanged (om, cmd, cid, tid, bte, blen, cti, seg, cyc, stb, we, asid, pl, pri, cache, csr, vadr).
  - LO beat: padr=padr&~15, sel=sel[7:0], dat=data1[63:0], sz=octa when split (else original sz).
  - HI beat: padr=(padr&~15)+8, sel=sel[15:8], dat=data1[127:64], sz as LO.
- States:
  - IDLE: on accept -> ISS_LO, ISS_HI or ERR per classification.
  - ISS_LO: drive LO beat with cyc=stb=1. If resp64_i.stall=0 that cycle, the beat is issued: go to ISS_HI if split, else WAIT. If stall=1, hold all fields stable.
  - ISS_HI: as ISS_LO, then -> WAIT.
  - WAIT: req64_o.cyc=stb=0; count acks in issue order.
    - First ack captures dat into the lane of the first beat issued.
    - Second ack (split only) captures the high lane.
    - err/rty are OR-accumulated.
    - When all expected acks are received -> RESP.
  - RESP: one cycle. resp128_o.ack=1, err/rty per accumulated values, cid/tid/pri from the latched request, adr=latched padr.
    - dat: split gives {hi,lo}; single beat gives {2{dat64}}.
    - Next state IDLE; a new request can be accepted the following cycle.
  - ERR: one cycle with resp128_o.ack=1, err=1, dat=0, no downstream traffic -> IDLE.
- Ack arriving in the same cycle as a beat issue: counted in that cycle. An ack in ISS_HI belongs to the LO beat.
- Timeout: the counter clears on each issue and each ack and increments in WAIT. At TMO: assert err, respond as in RESP with missing lanes 0, go to IDLE. Stale acks arriving later in IDLE are ignored.
- resp128_o.next=0 and stall=1 outside IDLE. ack is a single-cycle pulse.
- Latency (no stall, ack N cycles after issue): single beat, response N+2 cycles after accept; split, N+3 cycles.
- Reset mid-transaction: immediate return to IDLE and outputs zeroed; in-flight acks are dropped.

Test Plan:
1. Tetra read, sel=16'h00F0, padr=0x1004 -> one beat: padr=0x1000, sel=8'hF0. Slave ack dat=0x11223344_55667788 -> resp dat={2{that}}, ack pulse, err=0.
2. Hexi write, sel=16'hFFFF, padr=0x2000, data1=0xAAAA..BBBB -> beats: (0x2000, sel FF, dat low 64) then (0x2008, sel FF, dat high 64); one resp ack only after both acks.
3. Hexi read, downstream stall=1 for 3 cycles on the HI beat -> HI fields held stable; resp dat={ack2,ack1}; upstream stall=1 throughout.
4. Octa request -> resp err=1 one cycle after accept; req64_o.cyc never asserted.
5. Split read with second ack withheld, TMO=15 -> err response after 15 WAIT cycles; late ack in IDLE produces no upstream response.
6. Assert rst_i asynchronously during ISS_HI -> req64_o.cyc=0 immediately, resp128_o.stall=0; a new byte read then completes normally.
